// File: rtl/serial_magnitude_comparator_if.sv
// Start/busy/done handshake bundle for the serial magnitude comparator:
// operands and cascade inputs in, result and status out.
interface serial_magnitude_comparator_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = $clog2(NIB) + 1;

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             GT_in;
  logic             LT_in;
  logic             EQ_in;
  logic             busy;
  logic             done;
  logic             GT_out;
  logic             LT_out;
  logic             EQ_out;
  logic [CW-1:0]    nib_count;

  modport master (
    output start, A, B, GT_in, LT_in, EQ_in,
    input  busy, done, GT_out, LT_out, EQ_out, nib_count
  );

  modport slave (
    input  start, A, B, GT_in, LT_in, EQ_in,
    output busy, done, GT_out, LT_out, EQ_out, nib_count
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// MSB-first, one-nibble-per-clock magnitude comparator with GT/LT/EQ cascade
// inputs; stops on the first unequal nibble.
module serial_magnitude_comparator #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_magnitude_comparator_if.slave  bus
);
  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = $clog2(NIB) + 1;
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       casc_q, casc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;

  logic [3:0]       a_nib_c;
  logic [3:0]       b_nib_c;

  assign a_nib_c = 4'(a_q >> {idx_q, 2'b00});
  assign b_nib_c = 4'(b_q >> {idx_q, 2'b00});

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      casc_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      casc_q  <= casc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  // Next state: leave CMP on the first unequal nibble or after the LSB nibble
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = CMP;
      CMP:  if ((a_nib_c != b_nib_c) || (idx_q == '0)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the datapath and the registered outputs
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    casc_d = casc_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    gt_d   = gt_q;
    lt_d   = lt_q;
    eq_d   = eq_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d    = bus.A;
          b_d    = bus.B;
          casc_d = {bus.GT_in, bus.LT_in, bus.EQ_in};
          idx_d  = IW'(NIB - 1);
          cnt_d  = '0;
          gt_d   = 1'b0;
          lt_d   = 1'b0;
          eq_d   = 1'b0;
        end
      end
      CMP: begin
        cnt_d = CW'(cnt_q + 1'b1);
        if (a_nib_c > b_nib_c) begin
          gt_d = 1'b1;
        end else if (a_nib_c < b_nib_c) begin
          lt_d = 1'b1;
        end else if (idx_q != '0) begin
          idx_d = IW'(idx_q - 1'b1);
        end else begin
          // Only a one-hot cascade is meaningful; anything else yields no result
          case (casc_q)
            3'b100:  gt_d = 1'b1;
            3'b010:  lt_d = 1'b1;
            3'b001:  eq_d = 1'b1;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.GT_out    = gt_q;
  assign bus.LT_out    = lt_q;
  assign bus.EQ_out    = eq_q;
  assign bus.nib_count = cnt_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator (WIDTH=16): latency, result,
// nib_count, handshake, abort and back-to-back behaviour.
module tb_serial_magnitude_comparator;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  serial_magnitude_comparator_if #(.WIDTH(16)) bus ();

  serial_magnitude_comparator #(.WIDTH(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b,
                        input logic gt, input logic lt, input logic eq);
    bus.A     = a;
    bus.B     = b;
    bus.GT_in = gt;
    bus.LT_in = lt;
    bus.EQ_in = eq;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic gt, input logic lt, input logic eq,
                     input logic [2:0] exp_res, input int exp_k);
    int cyc;
    launch(a, b, gt, lt, eq);
    wait_done(cyc);
    check($sformatf("%s_latency", tag), cyc, exp_k);
    check($sformatf("%s_result", tag), {bus.GT_out, bus.LT_out, bus.EQ_out}, exp_res);
    check($sformatf("%s_nibcount", tag), bus.nib_count, exp_k);
    check($sformatf("%s_busy_in_done", tag), bus.busy, 1'b1);
    tick();
    check($sformatf("%s_done_pulse", tag), bus.done, 1'b0);
    check($sformatf("%s_busy_idle", tag), bus.busy, 1'b0);
  endtask

  initial begin
    int cyc;
    logic seen;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.GT_in = 1'b0;
    bus.LT_in = 1'b0;
    bus.EQ_in = 1'b0;
    tick();
    tick();
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_result", {bus.GT_out, bus.LT_out, bus.EQ_out}, 3'b000);
    check("reset_nibcount", bus.nib_count, 3'd0);
    rst = 1'b0;
    tick();

    run("eq_cascade",  16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 3'b001, 4);
    run("gt_msb",      16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1, 3'b100, 1);
    run("lt_lsb",      16'h1230, 16'h1235, 1'b0, 1'b0, 1'b1, 3'b010, 4);
    run("casc_gt",     16'hABCD, 16'hABCD, 1'b1, 1'b0, 1'b0, 3'b100, 4);
    run("casc_lt",     16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 3'b010, 4);
    run("casc_gtlt",   16'h5A5A, 16'h5A5A, 1'b1, 1'b1, 1'b0, 3'b000, 4);
    run("casc_none",   16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 3'b000, 4);
    run("lt_nib2",     16'h12F0, 16'h1300, 1'b0, 1'b0, 1'b1, 3'b010, 2);

    // Result and count hold while idle; changing inputs without start has no effect
    bus.A = 16'hFFFF;
    bus.B = 16'h0000;
    tick();
    tick();
    tick();
    check("hold_result", {bus.GT_out, bus.LT_out, bus.EQ_out}, 3'b010);
    check("hold_nibcount", bus.nib_count, 3'd2);

    // Start pulse and operand changes during CMP are ignored
    launch(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b1);
    bus.start = 1'b1;
    bus.A     = 16'hFFFF;
    bus.B     = 16'h0000;
    tick();
    bus.start = 1'b0;
    wait_done(cyc);
    check("busy_start_latency", cyc + 1, 4);
    check("busy_start_result", {bus.GT_out, bus.LT_out, bus.EQ_out}, 3'b010);
    check("busy_start_nibcount", bus.nib_count, 3'd4);
    tick();

    // Reset mid-comparison aborts with no done pulse
    launch(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b1);
    tick();
    check("abort_busy_before", bus.busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_result", {bus.GT_out, bus.LT_out, bus.EQ_out}, 3'b000);
    check("abort_nibcount", bus.nib_count, 3'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | bus.done;
    end
    check("abort_no_done", seen, 1'b0);
    run("post_abort", 16'h00A5, 16'h00A5, 1'b0, 1'b0, 1'b1, 3'b001, 4);

    // Held start: back-to-back comparisons every k+2 = 3 cycles
    bus.A     = 16'hF000;
    bus.B     = 16'h0000;
    bus.GT_in = 1'b0;
    bus.LT_in = 1'b0;
    bus.EQ_in = 1'b1;
    bus.start = 1'b1;
    tick();
    wait_done(cyc);
    check("b2b_first_latency", cyc, 1);
    check("b2b_first_result", {bus.GT_out, bus.LT_out, bus.EQ_out}, 3'b100);
    for (int r = 0; r < 2; r++) begin
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (bus.done !== 1'b1 && cyc < 40);
      check($sformatf("b2b_period_%0d", r), cyc, 3);
      check($sformatf("b2b_result_%0d", r), {bus.GT_out, bus.LT_out, bus.EQ_out}, 3'b100);
      check($sformatf("b2b_nibcount_%0d", r), bus.nib_count, 3'd1);
    end
    bus.start = 1'b0;
    tick();
    tick();
    check("b2b_idle", bus.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
